// File: rtl/dual_mac_sched_if.sv
// Bundle of buffer-read, dual-multiplier and result-handshake signals around dual_mac_sched.
// The master view belongs to the scheduler; the slave view belongs to buffers, multiplier and sink.
interface dual_mac_sched_if #(
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 24
);
    logic              start;
    logic              busy;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        act_a;
    logic [7:0]        act_b;
    logic [7:0]        wgt;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [7:0]        mul_c;
    logic              mul_valid;
    logic [16:0]       mul_prod_ac;
    logic [16:0]       mul_prod_bc;
    logic              mul_o_valid;
    logic              o_valid;
    logic              o_ready;
    logic [ACC_W-1:0]  o_acc_a;
    logic [ACC_W-1:0]  o_acc_b;

    modport master (
        input  start, act_a, act_b, wgt, mul_prod_ac, mul_prod_bc, mul_o_valid, o_ready,
        output busy, buf_rd_en, buf_addr, mul_a, mul_b, mul_c, mul_valid, o_valid, o_acc_a, o_acc_b
    );

    modport slave (
        output start, act_a, act_b, wgt, mul_prod_ac, mul_prod_bc, mul_o_valid, o_ready,
        input  busy, buf_rd_en, buf_addr, mul_a, mul_b, mul_c, mul_valid, o_valid, o_acc_a, o_acc_b
    );
endinterface

// File: rtl/dual_mac_sched.sv
// Sequences one shared-weight dot product of KLEN terms for two adjacent pixels through
// a packed dual 8x8 multiplier and holds both sums until the downstream stage accepts them.
module dual_mac_sched #(
    parameter int KLEN     = 9,
    parameter int ADDR_W   = 4,
    parameter int ACC_W    = 24,
    parameter int MULT_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    dual_mac_sched_if.master  bus
);

    // One extra count bit so the value KLEN is representable when 2**ADDR_W == KLEN.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KLEN - 1);

    if (KLEN < 1 || (2 ** ADDR_W) < KLEN || ACC_W < 17 || MULT_LAT < 1) begin : g_param_err
        $error("dual_mac_sched: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  issue_cnt_r;
    logic [CNT_W-1:0]  ret_cnt_r;
    logic [ACC_W-1:0]  acc_a_r;
    logic [ACC_W-1:0]  acc_b_r;
    logic              busy_r;
    logic              rd_en_r;
    logic              o_valid_r;
    logic              mul_valid_r;
    logic [7:0]        mul_a_r;
    logic [7:0]        mul_b_r;
    logic [7:0]        mul_c_r;
    logic              busy_nxt_s;
    logic              rd_en_nxt_s;
    logic              o_valid_nxt_s;
    logic              ret_fire_s;
    logic              start_fire_s;

    function automatic logic [ACC_W-1:0] sext17(input logic [16:0] p);
        sext17 = ACC_W'($signed(p));
    endfunction

    // Products only count while a dot product is in flight; strays in IDLE/HOLD are dropped.
    assign ret_fire_s   = bus.mul_o_valid && ((state_r == ST_ISSUE) || (state_r == ST_DRAIN));
    assign start_fire_s = (state_r == ST_IDLE) && bus.start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (bus.start) state_nxt_s = ST_ISSUE; else state_nxt_s = ST_IDLE;
            ST_ISSUE: if (issue_cnt_r == LAST_IDX) state_nxt_s = ST_DRAIN; else state_nxt_s = ST_ISSUE;
            ST_DRAIN: if (ret_fire_s && (ret_cnt_r == LAST_IDX)) state_nxt_s = ST_HOLD;
                      else state_nxt_s = ST_DRAIN;
            ST_HOLD:  if (bus.o_ready) state_nxt_s = ST_IDLE; else state_nxt_s = ST_HOLD;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the status flags register in step with the state.
    always_comb begin
        busy_nxt_s    = (state_nxt_s != ST_IDLE);
        rd_en_nxt_s   = (state_nxt_s == ST_ISSUE);
        o_valid_nxt_s = (state_nxt_s == ST_HOLD);
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r    <= 1'b0;
            rd_en_r   <= 1'b0;
            o_valid_r <= 1'b0;
        end else begin
            busy_r    <= busy_nxt_s;
            rd_en_r   <= rd_en_nxt_s;
            o_valid_r <= o_valid_nxt_s;
        end
    end

    // Issue/return counters and the two accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_r <= {CNT_W{1'b0}};
            ret_cnt_r   <= {CNT_W{1'b0}};
            acc_a_r     <= {ACC_W{1'b0}};
            acc_b_r     <= {ACC_W{1'b0}};
        end else if (start_fire_s) begin
            issue_cnt_r <= {CNT_W{1'b0}};
            ret_cnt_r   <= {CNT_W{1'b0}};
            acc_a_r     <= {ACC_W{1'b0}};
            acc_b_r     <= {ACC_W{1'b0}};
        end else begin
            if (state_r == ST_ISSUE) begin
                issue_cnt_r <= issue_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (ret_fire_s) begin
                ret_cnt_r <= ret_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                acc_a_r   <= acc_a_r + sext17(bus.mul_prod_ac);
                acc_b_r   <= acc_b_r + sext17(bus.mul_prod_bc);
            end
        end
    end

    // Read-data capture: operands latched on the read cycle and held between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_valid_r <= 1'b0;
            mul_a_r     <= 8'd0;
            mul_b_r     <= 8'd0;
            mul_c_r     <= 8'd0;
        end else begin
            mul_valid_r <= rd_en_r;
            if (rd_en_r) begin
                mul_a_r <= bus.act_a;
                mul_b_r <= bus.act_b;
                mul_c_r <= bus.wgt;
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.buf_rd_en = rd_en_r;
    assign bus.buf_addr  = issue_cnt_r[ADDR_W-1:0];
    assign bus.mul_valid = mul_valid_r;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;
    assign bus.mul_c     = mul_c_r;
    assign bus.o_valid   = o_valid_r;
    assign bus.o_acc_a   = acc_a_r;
    assign bus.o_acc_b   = acc_b_r;

endmodule

// File: tb/tb_dual_mac_sched.sv
// Directed bench for dual_mac_sched: three instances (defaults, 17-bit accumulator, KLEN=1),
// each fed by a 3-stage dual-multiplier model and constant or address-ramped buffers.
module tb_dual_mac_sched;

    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   miss = 0;
    int   n;

    always #5 clk = ~clk;

    dual_mac_sched_if #(.ADDR_W(4), .ACC_W(24)) bus0 ();
    dual_mac_sched_if #(.ADDR_W(4), .ACC_W(17)) bus1 ();
    dual_mac_sched_if #(.ADDR_W(1), .ACC_W(24)) bus2 ();

    dual_mac_sched #(.KLEN(9), .ADDR_W(4), .ACC_W(24), .MULT_LAT(3)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    dual_mac_sched #(.KLEN(9), .ADDR_W(4), .ACC_W(17), .MULT_LAT(3)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    dual_mac_sched #(.KLEN(1), .ADDR_W(1), .ACC_W(24), .MULT_LAT(3)) u2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [7:0] a0, b0, w0;
    logic       ramp0, inj0;

    // Buffers for u0: constants, or a ramp act_a=addr+1, act_b=-addr, wgt=2.
    assign bus0.act_a = ramp0 ? (8'(bus0.buf_addr) + 8'd1) : a0;
    assign bus0.act_b = ramp0 ? (8'd0 - 8'(bus0.buf_addr)) : b0;
    assign bus0.wgt   = ramp0 ? 8'd2 : w0;
    assign bus1.act_a = 8'd127;
    assign bus1.act_b = 8'h80;
    assign bus1.wgt   = 8'hFF;
    assign bus2.act_a = 8'hFB;
    assign bus2.act_b = 8'd7;
    assign bus2.wgt   = 8'd200;

    function automatic logic [16:0] mprod(input logic [7:0] a, input logic [7:0] c);
        logic signed [16:0] sa;
        logic signed [16:0] sc;
        sa = {{9{a[7]}}, a};
        sc = {9'd0, c};
        mprod = sa * sc;
    endfunction

    logic [2:0]  v0, v1, v2;
    logic [16:0] pa0 [3];
    logic [16:0] pb0 [3];
    logic [16:0] pa1 [3];
    logic [16:0] pb1 [3];
    logic [16:0] pa2 [3];
    logic [16:0] pb2 [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            v0 <= 3'd0;
            v1 <= 3'd0;
            v2 <= 3'd0;
        end else begin
            v0 <= {v0[1:0], bus0.mul_valid};
            v1 <= {v1[1:0], bus1.mul_valid};
            v2 <= {v2[1:0], bus2.mul_valid};
        end
    end

    always @(posedge clk) begin
        pa0[0] <= mprod(bus0.mul_a, bus0.mul_c); pa0[1] <= pa0[0]; pa0[2] <= pa0[1];
        pb0[0] <= mprod(bus0.mul_b, bus0.mul_c); pb0[1] <= pb0[0]; pb0[2] <= pb0[1];
        pa1[0] <= mprod(bus1.mul_a, bus1.mul_c); pa1[1] <= pa1[0]; pa1[2] <= pa1[1];
        pb1[0] <= mprod(bus1.mul_b, bus1.mul_c); pb1[1] <= pb1[0]; pb1[2] <= pb1[1];
        pa2[0] <= mprod(bus2.mul_a, bus2.mul_c); pa2[1] <= pa2[0]; pa2[2] <= pa2[1];
        pb2[0] <= mprod(bus2.mul_b, bus2.mul_c); pb2[1] <= pb2[0]; pb2[2] <= pb2[1];
    end

    // inj0 forces a stray return with a large product onto u0.
    assign bus0.mul_o_valid = v0[2] | inj0;
    assign bus0.mul_prod_ac = inj0 ? 17'd1000 : pa0[2];
    assign bus0.mul_prod_bc = inj0 ? 17'd1000 : pb0[2];
    assign bus1.mul_o_valid = v1[2];
    assign bus1.mul_prod_ac = pa1[2];
    assign bus1.mul_prod_bc = pb1[2];
    assign bus2.mul_o_valid = v2[2];
    assign bus2.mul_prod_ac = pa2[2];
    assign bus2.mul_prod_bc = pb2[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ov(input int k);
        case (k)
            0:       ov = bus0.o_valid;
            1:       ov = bus1.o_valid;
            default: ov = bus2.o_valid;
        endcase
    endfunction

    // Start sampled at edge 0; returns 1 time unit after that edge.
    task automatic pulse_start(input int k);
        @(negedge clk);
        case (k)
            0:       bus0.start = 1'b1;
            1:       bus1.start = 1'b1;
            default: bus2.start = 1'b1;
        endcase
        tick();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        bus2.start = 1'b0;
    endtask

    task automatic wait_valid(input int k, input int n0, output int nn);
        nn = n0;
        while (!ov(k) && nn < 60) begin
            tick();
            nn++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
        bus0.o_ready = 1'b0; bus1.o_ready = 1'b0; bus2.o_ready = 1'b0;
        a0 = 8'd0; b0 = 8'd0; w0 = 8'd0; ramp0 = 1'b0; inj0 = 1'b0;
        repeat (3) tick();
        chk("rst_busy", bus0.busy, 32'd0);
        chk("rst_rd_en", bus0.buf_rd_en, 32'd0);
        chk("rst_o_valid", bus0.o_valid, 32'd0);
        chk("rst_mul_valid", bus0.mul_valid, 32'd0);
        chk("rst_acc_a", bus0.o_acc_a, 32'd0);
        chk("rst_mul_a", bus0.mul_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Ones: A=+1, B=-1, w=1, addresses walked 0..8, o_valid after edge 13.
        a0 = 8'd1; b0 = 8'hFF; w0 = 8'd1;
        pulse_start(0);
        for (int i = 0; i < 9; i++) begin
            chk("t1_rd_en", bus0.buf_rd_en, 32'd1);
            chk("t1_addr", bus0.buf_addr, 32'(i));
            tick();
        end
        chk("t1_rd_en_off", bus0.buf_rd_en, 32'd0);
        wait_valid(0, 9, n);
        chk("t1_lat", n, 32'd13);
        chk("t1_acc_a", bus0.o_acc_a, 32'h000009);
        chk("t1_acc_b", bus0.o_acc_b, 32'hFFFFF7);
        bus0.o_ready = 1'b1;
        tick();
        chk("t1_ov_drop", bus0.o_valid, 32'd0);
        chk("t1_busy_drop", bus0.busy, 32'd0);
        bus0.o_ready = 1'b0;

        // Extremes, then a 20-cycle stall with start and a stray return during HOLD.
        a0 = 8'h80; b0 = 8'd127; w0 = 8'hFF;
        pulse_start(0);
        wait_valid(0, 0, n);
        chk("t2_lat", n, 32'd13);
        chk("t2_acc_a", bus0.o_acc_a, 32'hFB8480);
        chk("t2_acc_b", bus0.o_acc_b, 32'h047289);
        for (int i = 0; i < 20; i++) begin
            bus0.start = (i == 5);
            inj0 = (i == 8);
            chk("t2_hold_ov", bus0.o_valid, 32'd1);
            chk("t2_hold_busy", bus0.busy, 32'd1);
            chk("t2_hold_acc_a", bus0.o_acc_a, 32'hFB8480);
            chk("t2_hold_acc_b", bus0.o_acc_b, 32'h047289);
            tick();
        end
        bus0.start = 1'b0;
        inj0 = 1'b0;
        bus0.o_ready = 1'b1;
        tick();
        bus0.o_ready = 1'b0;
        chk("t2_ov_drop", bus0.o_valid, 32'd0);
        tick();
        chk("t2_idle_busy", bus0.busy, 32'd0);
        chk("t2_idle_rd_en", bus0.buf_rd_en, 32'd0);
        chk("t2_mul_a_hold", bus0.mul_a, 32'h80);
        chk("t2_mul_b_hold", bus0.mul_b, 32'h7F);
        chk("t2_mul_c_hold", bus0.mul_c, 32'hFF);

        // Address ramp with o_ready high in advance: A=2*45, B=-2*36.
        ramp0 = 1'b1;
        bus0.o_ready = 1'b1;
        pulse_start(0);
        wait_valid(0, 0, n);
        chk("t3_lat", n, 32'd13);
        chk("t3_acc_a", bus0.o_acc_a, 32'h00005A);
        chk("t3_acc_b", bus0.o_acc_b, 32'hFFFFB8);
        tick();
        chk("t3_busy_drop", bus0.busy, 32'd0);
        chk("t3_ov_drop", bus0.o_valid, 32'd0);
        ramp0 = 1'b0;

        // Reset after edge 5 of an operation, then a clean rerun: 9*30, 9*50.
        a0 = 8'd3; b0 = 8'd5; w0 = 8'd10;
        pulse_start(0);
        repeat (5) tick();
        chk("t4_partial", bus0.o_acc_a, 32'd30);
        rst = 1'b1;
        #1;
        chk("t4_rst_busy", bus0.busy, 32'd0);
        chk("t4_rst_rd_en", bus0.buf_rd_en, 32'd0);
        chk("t4_rst_mul_valid", bus0.mul_valid, 32'd0);
        chk("t4_rst_addr", bus0.buf_addr, 32'd0);
        chk("t4_rst_acc_a", bus0.o_acc_a, 32'd0);
        chk("t4_rst_acc_b", bus0.o_acc_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick();
        pulse_start(0);
        wait_valid(0, 0, n);
        chk("t4_lat", n, 32'd13);
        chk("t4_acc_a", bus0.o_acc_a, 32'd270);
        chk("t4_acc_b", bus0.o_acc_b, 32'd450);
        tick();

        // Stray returns while IDLE leave the held sums and the next result untouched.
        inj0 = 1'b1;
        repeat (3) tick();
        inj0 = 1'b0;
        chk("t5_idle_acc_a", bus0.o_acc_a, 32'd270);
        chk("t5_idle_acc_b", bus0.o_acc_b, 32'd450);
        chk("t5_idle_busy", bus0.busy, 32'd0);
        a0 = 8'd2; b0 = 8'hFD; w0 = 8'd4;
        pulse_start(0);
        wait_valid(0, 0, n);
        chk("t5_acc_a", bus0.o_acc_a, 32'd72);
        chk("t5_acc_b", bus0.o_acc_b, 32'hFFFF94);
        tick();
        bus0.o_ready = 1'b0;

        // 17-bit accumulator wraps: 9*32385 mod 2^17, 9*(-32640) mod 2^17.
        pulse_start(1);
        wait_valid(1, 0, n);
        chk("t6_lat", n, 32'd13);
        chk("t6_acc_a_wrap", bus1.o_acc_a, 32'd29321);
        chk("t6_acc_b_wrap", bus1.o_acc_b, 32'd99456);
        bus1.o_ready = 1'b1;
        tick();
        chk("t6_busy_drop", bus1.busy, 32'd0);

        // KLEN=1: single term, o_valid after edge 5.
        bus2.o_ready = 1'b1;
        pulse_start(2);
        wait_valid(2, 0, n);
        chk("t7_lat", n, 32'd5);
        chk("t7_busy", bus2.busy, 32'd1);
        chk("t7_acc_a", bus2.o_acc_a, 32'hFFFC18);
        chk("t7_acc_b", bus2.o_acc_b, 32'd1400);
        tick();
        chk("t7_busy_drop", bus2.busy, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
